// File: rtl/fifo_pipe_mc_if.sv
// Push, pop-arbitration, result and error bundle for fifo_pipe_mc.
// The master side issues pushes and pop requests; the slave side (the FIFO) answers.
interface fifo_pipe_mc_if #(
    parameter int NUM_CH         = 4,
    parameter int max_FIFO_WIDTH = 11
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                      push;
    logic [CH_W-1:0]           push_ch;
    logic [max_FIFO_WIDTH-1:0] push_data;
    logic [NUM_CH-1:0]         pop_req;
    logic [NUM_CH-1:0]         pop_gnt;
    logic [NUM_CH-1:0]         empty;
    logic [NUM_CH-1:0]         full;
    logic                      out_valid;
    logic [max_FIFO_WIDTH-1:0] pop_data;
    logic [CH_W-1:0]           out_ch;
    logic                      ovf_err;
    logic                      udf_err;
    logic                      err_clr;

    modport master (
        output push, push_ch, push_data, pop_req, err_clr,
        input  pop_gnt, empty, full, out_valid, pop_data, out_ch, ovf_err, udf_err
    );

    modport slave (
        input  push, push_ch, push_data, pop_req, err_clr,
        output pop_gnt, empty, full, out_valid, pop_data, out_ch, ovf_err, udf_err
    );
endinterface

// File: rtl/fifo_pipe_mc.sv
// Multi-channel FIFO with a round-robin pop arbiter feeding a configurable-length
// arithmetic pipeline; results emerge tagged with their source channel.
module fifo_pipe_mc #(
    parameter int NUM_CH         = 4,
    parameter int max_FIFO_DEPTH = 8,
    parameter int max_FIFO_WIDTH = 11,
    parameter int max_NUM_LOOPS  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    fifo_pipe_mc_if.slave                     bus,
    input  logic [$clog2(max_FIFO_DEPTH):0]   sig_FIFO_DEPTH,
    input  logic [$clog2(max_FIFO_WIDTH):0]   sig_FIFO_WIDTH,
    input  logic [$clog2(max_NUM_LOOPS):0]    sig_NUM_LOOPS,
    input  logic [1:0]                        sig_ADD_MODE,
    input  logic [max_FIFO_WIDTH-1:0]         sig_STEP
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W  = (max_FIFO_DEPTH > 1) ? $clog2(max_FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(max_FIFO_DEPTH) + 1;
    localparam int LOOP_W = $clog2(max_NUM_LOOPS) + 1;
    localparam int W      = max_FIFO_WIDTH;
    localparam int NL     = max_NUM_LOOPS;

    localparam logic [1:0] MODE_SUB  = 2'b00;
    localparam logic [1:0] MODE_ADD  = 2'b01;
    localparam logic [1:0] MODE_PASS = 2'b10;

    logic [W-1:0]      mem    [NUM_CH][max_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [LVL_W-1:0]  level  [NUM_CH];
    logic [CH_W-1:0]   last_gnt;

    logic [W-1:0]      data_mask;
    logic [LVL_W-1:0]  depth_m1;
    logic [NUM_CH-1:0] empty_v;
    logic [NUM_CH-1:0] full_v;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] wr_hit;
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   cand;
    logic              push_ok;
    logic              ovf_ev;
    logic              udf_ev;
    logic [W-1:0]      rd_word;
    logic              ovf_q;
    logic              udf_q;

    logic [NL:1]       stg_vld;
    logic [W-1:0]      stg_data [1:NL];
    logic [CH_W-1:0]   stg_ch   [1:NL];

    logic              sel_vld;
    logic [W-1:0]      sel_data;
    logic [CH_W-1:0]   sel_ch;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                                 input logic [LVL_W-1:0] last);
        return (LVL_W'(p) == last) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] x,
                                              input logic [1:0]   mode,
                                              input logic [W-1:0] step,
                                              input logic [W-1:0] mask);
        logic [W-1:0] r;
        case (mode)
            MODE_SUB:  r = x - step;
            MODE_ADD:  r = x + step;
            MODE_PASS: r = x;
            default:   r = x ^ step;
        endcase
        return r & mask;
    endfunction

    assign depth_m1 = sig_FIFO_DEPTH - LVL_W'(1);

    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_mask = '0;
        for (int b = 0; b < W; b++) begin
            data_mask[b] = (b < int'(sig_FIFO_WIDTH));
        end
    end

    always_comb begin
        empty_v = '0;
        full_v  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_v[c] = (level[c] == '0);
            full_v[c]  = (level[c] == sig_FIFO_DEPTH);
        end
    end

    // Fullness is judged on the start-of-cycle level, so a same-cycle pop never rescues a push.
    assign push_ok  = bus.push && !full_v[bus.push_ch];
    assign ovf_ev   = bus.push &&  full_v[bus.push_ch];
    assign udf_ev   = |(bus.pop_req & empty_v);
    assign eligible = bus.pop_req & ~empty_v;
    assign wr_hit   = push_ok ? (NUM_CH'(1) << bus.push_ch) : '0;

    // NOTE: combinational logic uses blocking '=' so the search variable updates in
    // program order within one evaluation; registers below use '<=' exclusively.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = last_gnt;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + 1'b1;
            if (!gnt_any && eligible[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign rd_word = mem[gnt_idx][rd_ptr[gnt_idx]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                level[c]  <= '0;
            end
            last_gnt <= CH_W'(NUM_CH - 1);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c]) begin
                    wr_ptr[c] <= ptr_inc(wr_ptr[c], depth_m1);
                end
                if (gnt[c]) begin
                    rd_ptr[c] <= ptr_inc(rd_ptr[c], depth_m1);
                end
                if (wr_hit[c] && !gnt[c]) begin
                    level[c] <= level[c] + 1'b1;
                end else if (!wr_hit[c] && gnt[c]) begin
                    level[c] <= level[c] - 1'b1;
                end
            end
            if (gnt_any) begin
                last_gnt <= gnt_idx;
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers and levels alone define
    // which entries are live, so stale contents are never observable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_hit[c]) begin
                mem[c][wr_ptr[c]] <= bus.push_data & data_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ovf_ev) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_q <= 1'b0;
            end
            if (udf_ev) begin
                udf_q <= 1'b1;
            end else if (bus.err_clr) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Stage k holds the word after k applications; the output tap selects stage sig_NUM_LOOPS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_vld <= '0;
            for (int k = 1; k <= NL; k++) begin
                stg_data[k] <= '0;
                stg_ch[k]   <= '0;
            end
        end else begin
            stg_vld[1]  <= gnt_any;
            stg_data[1] <= gnt_any ? apply_op(rd_word, sig_ADD_MODE, sig_STEP, data_mask) : '0;
            stg_ch[1]   <= gnt_any ? gnt_idx : '0;
            for (int k = 2; k <= NL; k++) begin
                stg_vld[k]  <= stg_vld[k-1];
                stg_data[k] <= apply_op(stg_data[k-1], sig_ADD_MODE, sig_STEP, data_mask);
                stg_ch[k]   <= stg_ch[k-1];
            end
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        sel_ch   = '0;
        for (int k = 1; k <= NL; k++) begin
            if (sig_NUM_LOOPS == LOOP_W'(k)) begin
                sel_vld  = stg_vld[k];
                sel_data = stg_data[k];
                sel_ch   = stg_ch[k];
            end
        end
    end

    assign bus.pop_gnt   = gnt;
    assign bus.empty     = empty_v;
    assign bus.full      = full_v;
    assign bus.out_valid = sel_vld;
    assign bus.pop_data  = sel_vld ? sel_data : '0;
    assign bus.out_ch    = sel_vld ? sel_ch : '0;
    assign bus.ovf_err   = ovf_q;
    assign bus.udf_err   = udf_q;
endmodule

// File: tb/tb_fifo_pipe_mc.sv
// Bench for fifo_pipe_mc: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference model of the channels, arbiter and result pipeline.
module tb_fifo_pipe_mc;
    localparam int NCH  = 4;
    localparam int MAXD = 8;
    localparam int MAXW = 11;
    localparam int MAXL = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sig_FIFO_DEPTH;
    logic [4:0]  sig_FIFO_WIDTH;
    logic [3:0]  sig_NUM_LOOPS;
    logic [1:0]  sig_ADD_MODE;
    logic [10:0] sig_STEP;

    fifo_pipe_mc_if #(.NUM_CH(NCH), .max_FIFO_WIDTH(MAXW)) bus ();

    fifo_pipe_mc #(
        .NUM_CH(NCH), .max_FIFO_DEPTH(MAXD), .max_FIFO_WIDTH(MAXW), .max_NUM_LOOPS(MAXL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sig_FIFO_DEPTH(sig_FIFO_DEPTH),
        .sig_FIFO_WIDTH(sig_FIFO_WIDTH),
        .sig_NUM_LOOPS(sig_NUM_LOOPS),
        .sig_ADD_MODE(sig_ADD_MODE),
        .sig_STEP(sig_STEP)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int data;
        int ch;
    } result_t;

    int      mq [NCH][$];
    result_t pend[$];
    int      m_last, m_ovf, m_udf, cyc;
    int      cfg_depth, cfg_width, cfg_loops, cfg_mode, cfg_step;
    int      obs_data[$];
    int      obs_gnt[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int wmask();
        return (1 << cfg_width) - 1;
    endfunction

    // Closed-form result of cfg_loops applications of the selected operation.
    function automatic int expect_result(input int x);
        case (cfg_mode)
            0:       return (x - cfg_loops * cfg_step) & wmask();
            1:       return (x + cfg_loops * cfg_step) & wmask();
            2:       return x & wmask();
            default: return ((cfg_loops % 2 == 1) ? (x ^ cfg_step) : x) & wmask();
        endcase
    endfunction

    function automatic int obs_at(input int i);
        return (i < obs_data.size()) ? obs_data[i] : -1;
    endfunction

    function automatic int gnt_at(input int i);
        return (i < obs_gnt.size()) ? obs_gnt[i] : -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        pend.delete();
        m_last = NCH - 1;
        m_ovf  = 0;
        m_udf  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_empty"}, 32'(bus.empty), 32'hF);
        check({tag, "_full"},  32'(bus.full), 0);
        check({tag, "_data"},  32'(bus.pop_data), 0);
        check({tag, "_ch"},    32'(bus.out_ch), 0);
        check({tag, "_gnt"},   32'(bus.pop_gnt), 0);
        check({tag, "_errs"},  32'({bus.ovf_err, bus.udf_err}), 0);
    endtask

    task automatic do_reset(input int d, input int w, input int l, input int m, input int s);
        rst           = 1'b1;
        bus.push      = 1'b0;
        bus.push_ch   = '0;
        bus.push_data = '0;
        bus.pop_req   = '0;
        bus.err_clr   = 1'b0;
        cfg_depth = d; cfg_width = w; cfg_loops = l; cfg_mode = m; cfg_step = s & ((1 << w) - 1);
        sig_FIFO_DEPTH = 4'(d);
        sig_FIFO_WIDTH = 5'(w);
        sig_NUM_LOOPS  = 4'(l);
        sig_ADD_MODE   = 2'(m);
        sig_STEP       = 11'(s);
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model, clock.
    task automatic step(input bit p, input int pch, input int pdata,
                        input logic [NCH-1:0] preq, input bit clr);
        int              gidx;
        int              c;
        logic [NCH-1:0]  exp_gnt, exp_empty, exp_full;
        result_t         r;
        bit              ovf_ev, udf_ev;
        bus.push      = p;
        bus.push_ch   = 2'(pch);
        bus.push_data = 11'(pdata);
        bus.pop_req   = preq;
        bus.err_clr   = clr;
        #4;
        for (int i = 0; i < NCH; i++) begin
            exp_empty[i] = (mq[i].size() == 0);
            exp_full[i]  = (mq[i].size() == cfg_depth);
        end
        gidx = -1;
        for (int i = 1; i <= NCH; i++) begin
            c = (m_last + i) % NCH;
            if (gidx < 0 && preq[c] && mq[c].size() > 0) gidx = c;
        end
        exp_gnt = (gidx >= 0) ? (NCH'(1) << gidx) : '0;
        check("pop_gnt", 32'(bus.pop_gnt), 32'(exp_gnt));
        check("empty",   32'(bus.empty),   32'(exp_empty));
        check("full",    32'(bus.full),    32'(exp_full));
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            check("out_valid", 32'(bus.out_valid), 1);
            check("pop_data",  32'(bus.pop_data), 32'(r.data));
            check("out_ch",    32'(bus.out_ch), 32'(r.ch));
        end else begin
            check("out_idle_valid", 32'(bus.out_valid), 0);
            check("out_idle_data",  32'(bus.pop_data), 0);
            check("out_idle_ch",    32'(bus.out_ch), 0);
        end
        check("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
        check("udf_err", 32'(bus.udf_err), 32'(m_udf));
        if (bus.out_valid) obs_data.push_back(int'(bus.pop_data));
        for (int i = 0; i < NCH; i++) if (bus.pop_gnt[i]) obs_gnt.push_back(i);

        ovf_ev = p && (mq[pch].size() >= cfg_depth);
        udf_ev = ((preq & exp_empty) != '0);
        if (gidx >= 0) begin
            r.due  = cyc + cfg_loops;
            r.data = expect_result(mq[gidx].pop_front());
            r.ch   = gidx;
            pend.push_back(r);
            m_last = gidx;
        end
        if (p && !ovf_ev) mq[pch].push_back(pdata & wmask());
        m_ovf = ovf_ev ? 1 : (clr ? 0 : m_ovf);
        m_udf = udf_ev ? 1 : (clr ? 0 : m_udf);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] preq);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, preq, 1'b0);
    endtask

    initial begin
        cyc = 0;

        // Two pushes to ch1, held request, three stages of +1.
        do_reset(5, 8, 3, 1, 1);
        obs_data.delete(); obs_gnt.delete();
        step(1'b1, 1, 10, 4'b0000, 1'b0);
        step(1'b1, 1, 20, 4'b0000, 1'b0);
        idle(6, 4'b0010);
        check("basic_count", 32'(obs_data.size()), 2);
        check("basic_d0", 32'(obs_at(0)), 13);
        check("basic_d1", 32'(obs_at(1)), 23);
        check("basic_gnts", 32'(obs_gnt.size()), 2);

        // Depth-5 overflow, ordered drain, then streaming through pointer wrap.
        do_reset(5, 11, 1, 2, 0);
        obs_data.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 0, i + 1, 4'b0000, 1'b0);
        check("ovf_full0", 32'(bus.full[0]), 1);
        check("ovf_flag", 32'(bus.ovf_err), 1);
        idle(7, 4'b0001);
        for (int i = 0; i < 5; i++) check("ovf_order", 32'(obs_at(i)), 32'(i + 1));
        check("ovf_count", 32'(obs_data.size()), 5);
        obs_data.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 0, 100 + i, 4'b0001, 1'b0);
        idle(3, 4'b0001);
        check("wrap_count", 32'(obs_data.size()), 12);
        for (int i = 0; i < 12; i++) check("wrap_order", 32'(obs_at(i)), 32'(100 + i));

        // Round-robin across four loaded channels.
        do_reset(8, 11, 1, 2, 0);
        for (int c = 0; c < NCH; c++) begin
            for (int j = 0; j < 2; j++) step(1'b1, c, c * 10 + j, 4'b0000, 1'b0);
        end
        obs_gnt.delete();
        idle(8, 4'b1111);
        for (int i = 0; i < 8; i++) check("rr_order", 32'(gnt_at(i)), 32'(i % NCH));

        // Narrow width: subtract wraps modulo 16, double XOR cancels.
        do_reset(8, 4, 2, 0, 3);
        obs_data.delete();
        step(1'b1, 0, 1, 4'b0000, 1'b0);
        idle(4, 4'b0001);
        check("sub_wrap", 32'(obs_at(0)), 11);
        do_reset(8, 4, 2, 3, 5);
        obs_data.delete();
        step(1'b1, 0, 1, 4'b0000, 1'b0);
        idle(4, 4'b0001);
        check("xor_twice", 32'(obs_at(0)), 1);

        // Underflow flag, clear, and error-wins-over-clear.
        do_reset(8, 11, 1, 2, 0);
        step(1'b0, 0, 0, 4'b0100, 1'b0);
        check("udf_set", 32'(bus.udf_err), 1);
        step(1'b0, 0, 0, 4'b0000, 1'b1);
        check("udf_clr", 32'(bus.udf_err), 0);
        step(1'b0, 0, 0, 4'b0100, 1'b1);
        check("udf_wins", 32'(bus.udf_err), 1);

        // Asynchronous reset with words in flight and ch0 holding four entries.
        do_reset(8, 11, 3, 1, 7);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 50 + i, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 60 + i, 4'b0000, 1'b0);
        idle(3, 4'b0010);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        check_reset_outputs("held");
        rst = 1'b0;
        model_reset();
        obs_data.delete();
        idle(6, 4'b1111);
        check("no_stale", 32'(obs_data.size()), 0);

        // Random traffic over several configurations, including depth 1 and odd depths.
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: do_reset(1, 11, 1, 1, 3);
                1: do_reset(7, 5, 4, 0, 9);
                2: do_reset(3, 1, 6, 3, 1);
                default: do_reset($urandom_range(1, MAXD), $urandom_range(1, MAXW),
                                  $urandom_range(1, MAXL), $urandom_range(0, 3), $urandom);
            endcase
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(0, 9) < 6, $urandom_range(0, NCH - 1), $urandom,
                     NCH'($urandom), $urandom_range(0, 9) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
